// File: rtl/clk_gen_pkg.sv
// Shared defaults and helpers for the multi-channel clock-divider generator.
package clk_gen_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned DIV_W_DEF = 3;

  // Limit a requested select to the widest divide the counter supports.
  function automatic int unsigned sel_clamp(input int unsigned sel, input int unsigned cnt_w);
    return (sel > cnt_w - 1) ? cnt_w - 1 : sel;
  endfunction

  // True when the low (sel+1) bits of the next count are all zero.
  function automatic logic is_boundary(input logic [31:0] cnt_next, input int unsigned sel);
    logic [32:0] mask;
    mask = (33'd1 << (sel + 1)) - 33'd1;
    return ({1'b0, cnt_next} & mask) == 33'd0;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: boundary-gated enable, registered output and edge strobes.
module clk_div_ch
  import clk_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt_next,
  input  logic [DIV_W-1:0] sel,
  input  logic             ch_en,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb
);

  logic active_en;
  logic en_nxt;
  logic out_nxt;

  // Enable only changes at a period start, where the output is low anyway,
  // so neither enabling nor disabling can cut a phase short.
  always_comb begin
    en_nxt = active_en;
    if (is_boundary(32'(cnt_next), 32'(sel))) en_nxt = ch_en;
    out_nxt = en_nxt & (|(cnt_next & (CNT_W'(1) << sel)));
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      active_en <= 1'b0;
      clk_out   <= 1'b0;
      rise_stb  <= 1'b0;
      fall_stb  <= 1'b0;
    end else begin
      active_en <= en_nxt;
      clk_out   <= out_nxt;
      rise_stb  <= ~clk_out & out_nxt;
      fall_stb  <= clk_out & ~out_nxt;
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel phase-aligned clock divider with wrap-synchronous reprogramming.
module clk_div_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned             N_CH    = 3,
  parameter int unsigned             CNT_W   = CNT_W_DEF,
  parameter int unsigned             DIV_W   = DIV_W_DEF,
  parameter logic [N_CH*DIV_W-1:0]   DEF_SEL = {3'd2, 3'd1, 3'd0}
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic [N_CH*DIV_W-1:0]  div_sel,
  input  logic                   load,
  input  logic [N_CH-1:0]        ch_en,
  output logic [N_CH-1:0]        clk_out,
  output logic [N_CH-1:0]        rise_stb,
  output logic [N_CH-1:0]        fall_stb,
  output logic                   busy,
  output logic                   cfg_err
);

  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic [N_CH*DIV_W-1:0]  sel_act;
  logic [N_CH*DIV_W-1:0]  sel_eff;
  logic [N_CH*DIV_W-1:0]  pending;
  logic [N_CH*DIV_W-1:0]  clamped;
  logic                   clamp_hit;
  logic                   apply;

  // Channels see the pending selects in the apply cycle itself so the new
  // ratios take effect on the same update that wraps the counter to zero.
  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    apply    = busy & (cnt_next == '0);
    sel_eff  = apply ? pending : sel_act;
  end

  always_comb begin
    clamped   = '0;
    clamp_hit = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      clamped[i*DIV_W +: DIV_W] = DIV_W'(sel_clamp(32'(div_sel[i*DIV_W +: DIV_W]), CNT_W));
      if (32'(div_sel[i*DIV_W +: DIV_W]) > CNT_W - 1) clamp_hit = 1'b1;
    end
  end

  // A load coinciding with an apply becomes the next pending value, so the
  // load assignments come after the apply ones.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt     <= '0;
      sel_act <= DEF_SEL;
      pending <= '0;
      busy    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      cfg_err <= load & clamp_hit;
      if (apply) begin
        sel_act <= pending;
        busy    <= 1'b0;
      end
      if (load) begin
        pending <= clamped;
        busy    <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W (CNT_W),
      .DIV_W (DIV_W)
    ) u_ch (
      .clk_in   (clk_in),
      .reset    (reset),
      .cnt_next (cnt_next),
      .sel      (sel_eff[g*DIV_W +: DIV_W]),
      .ch_en    (ch_en[g]),
      .clk_out  (clk_out[g]),
      .rise_stb (rise_stb[g]),
      .fall_stb (fall_stb[g])
    );
  end

endmodule
